// File: rtl/sr_instr_encoder_pkg.sv
// sr_instr_encoder_pkg: mnemonic codes, RV32I field encodings and packing helpers shared by encoder and decoder
package sr_instr_encoder_pkg;

   localparam logic [4:0] ENC_OP_ADD  = 5'd0;
   localparam logic [4:0] ENC_OP_SUB  = 5'd1;
   localparam logic [4:0] ENC_OP_OR   = 5'd2;
   localparam logic [4:0] ENC_OP_AND  = 5'd3;
   localparam logic [4:0] ENC_OP_XOR  = 5'd4;
   localparam logic [4:0] ENC_OP_SLL  = 5'd5;
   localparam logic [4:0] ENC_OP_SRL  = 5'd6;
   localparam logic [4:0] ENC_OP_SLTU = 5'd7;
   localparam logic [4:0] ENC_OP_ADDI = 5'd8;
   localparam logic [4:0] ENC_OP_ANDI = 5'd9;
   localparam logic [4:0] ENC_OP_ORI  = 5'd10;
   localparam logic [4:0] ENC_OP_XORI = 5'd11;
   localparam logic [4:0] ENC_OP_SLLI = 5'd12;
   localparam logic [4:0] ENC_OP_SRLI = 5'd13;
   localparam logic [4:0] ENC_OP_LUI  = 5'd14;
   localparam logic [4:0] ENC_OP_BEQ  = 5'd15;
   localparam logic [4:0] ENC_OP_BNE  = 5'd16;
   localparam logic [4:0] ENC_OP_BLT  = 5'd17;
   localparam logic [4:0] ENC_OP_BGE  = 5'd18;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [6:0] RVOP_OP     = 7'b0110011;
   localparam logic [6:0] RVOP_OPIMM  = 7'b0010011;
   localparam logic [6:0] RVOP_LUI    = 7'b0110111;
   localparam logic [6:0] RVOP_BRANCH = 7'b1100011;

   localparam logic [2:0] RVF3_ADD  = 3'b000;
   localparam logic [2:0] RVF3_SLL  = 3'b001;
   localparam logic [2:0] RVF3_SLTU = 3'b011;
   localparam logic [2:0] RVF3_XOR  = 3'b100;
   localparam logic [2:0] RVF3_SRL  = 3'b101;
   localparam logic [2:0] RVF3_OR   = 3'b110;
   localparam logic [2:0] RVF3_AND  = 3'b111;
   localparam logic [2:0] RVF3_BEQ  = 3'b000;
   localparam logic [2:0] RVF3_BNE  = 3'b001;
   localparam logic [2:0] RVF3_BLT  = 3'b100;
   localparam logic [2:0] RVF3_BGE  = 3'b101;

   localparam logic [6:0] RVF7_BASE = 7'b0000000;
   localparam logic [6:0] RVF7_SUB  = 7'b0100000;

   typedef struct packed {
      logic        err;
      logic [31:0] instr;
   } enc_word_t;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, RVOP_OP};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, RVOP_OPIMM};
   endfunction

   // branch offsets are even, so bit 0 is never encoded
   function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], RVOP_BRANCH};
   endfunction

endpackage

// File: rtl/sr_enc_pack.sv
// sr_enc_pack: combinational op+fields -> {err, instr}; SR_ENC_RANGECHK_EN enables immediate range checks
module sr_enc_pack
   import sr_instr_encoder_pkg::*;
(
   input  logic [4:0]  i_op,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [31:0] i_imm,
   output enc_word_t   o_word
);

   logic        w_i_bad;
   logic        w_sh_bad;
   logic        w_b_bad;
   logic        w_u_bad;
   logic        w_bad;
   logic [31:0] w_instr;

`ifdef SR_ENC_RANGECHK_EN
   assign w_i_bad  = !(i_imm[31:11] == '0 || &i_imm[31:11]);
   assign w_sh_bad = |i_imm[31:5];
   assign w_b_bad  = !(i_imm[31:12] == '0 || &i_imm[31:12]) || i_imm[0];
   assign w_u_bad  = |i_imm[11:0];
`else
   logic w_unused_imm0;
   assign w_unused_imm0 = i_imm[0];
   assign w_i_bad  = 1'b0;
   assign w_sh_bad = 1'b0;
   assign w_b_bad  = 1'b0;
   assign w_u_bad  = 1'b0;
`endif

   // select the format for the mnemonic; unknown codes and failed checks become a flagged NOP
   always_comb begin
      w_bad   = 1'b0;
      w_instr = NOP;
      case (i_op)
         ENC_OP_ADD:  w_instr = enc_r(RVF7_BASE, i_rs2, i_rs1, RVF3_ADD, i_rd);
         ENC_OP_SUB:  w_instr = enc_r(RVF7_SUB, i_rs2, i_rs1, RVF3_ADD, i_rd);
         ENC_OP_OR:   w_instr = enc_r(RVF7_BASE, i_rs2, i_rs1, RVF3_OR, i_rd);
         ENC_OP_AND:  w_instr = enc_r(RVF7_BASE, i_rs2, i_rs1, RVF3_AND, i_rd);
         ENC_OP_XOR:  w_instr = enc_r(RVF7_BASE, i_rs2, i_rs1, RVF3_XOR, i_rd);
         ENC_OP_SLL:  w_instr = enc_r(RVF7_BASE, i_rs2, i_rs1, RVF3_SLL, i_rd);
         ENC_OP_SRL:  w_instr = enc_r(RVF7_BASE, i_rs2, i_rs1, RVF3_SRL, i_rd);
         ENC_OP_SLTU: w_instr = enc_r(RVF7_BASE, i_rs2, i_rs1, RVF3_SLTU, i_rd);
         ENC_OP_ADDI: begin w_instr = enc_i(i_imm[11:0], i_rs1, RVF3_ADD, i_rd); w_bad = w_i_bad; end
         ENC_OP_ANDI: begin w_instr = enc_i(i_imm[11:0], i_rs1, RVF3_AND, i_rd); w_bad = w_i_bad; end
         ENC_OP_ORI:  begin w_instr = enc_i(i_imm[11:0], i_rs1, RVF3_OR, i_rd); w_bad = w_i_bad; end
         ENC_OP_XORI: begin w_instr = enc_i(i_imm[11:0], i_rs1, RVF3_XOR, i_rd); w_bad = w_i_bad; end
         ENC_OP_SLLI: begin w_instr = enc_i({RVF7_BASE, i_imm[4:0]}, i_rs1, RVF3_SLL, i_rd); w_bad = w_sh_bad; end
         ENC_OP_SRLI: begin w_instr = enc_i({RVF7_BASE, i_imm[4:0]}, i_rs1, RVF3_SRL, i_rd); w_bad = w_sh_bad; end
         ENC_OP_LUI:  begin w_instr = {i_imm[31:12], i_rd, RVOP_LUI}; w_bad = w_u_bad; end
         ENC_OP_BEQ:  begin w_instr = enc_b(i_imm[12:1], i_rs2, i_rs1, RVF3_BEQ); w_bad = w_b_bad; end
         ENC_OP_BNE:  begin w_instr = enc_b(i_imm[12:1], i_rs2, i_rs1, RVF3_BNE); w_bad = w_b_bad; end
         ENC_OP_BLT:  begin w_instr = enc_b(i_imm[12:1], i_rs2, i_rs1, RVF3_BLT); w_bad = w_b_bad; end
         ENC_OP_BGE:  begin w_instr = enc_b(i_imm[12:1], i_rs2, i_rs1, RVF3_BGE); w_bad = w_b_bad; end
         default:     w_bad = 1'b1;
      endcase
   end

   assign o_word = '{err: w_bad, instr: w_bad ? NOP : w_instr};

endmodule

// File: rtl/sr_instr_encoder.sv
// sr_instr_encoder: streaming RV32I encoder with one-entry output buffer, word address and error count; SR_ENC_RANGECHK_EN enables immediate range checks
module sr_instr_encoder
   import sr_instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic [7:0]        err_cnt
);

   logic              r_valid;
   logic [31:0]       r_instr;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_next;
   logic              r_err;
   logic [7:0]        r_err_cnt;
   logic              w_acc;
   enc_word_t         w_word;

   sr_enc_pack u_pack (
      .i_op   (in_op),
      .i_rd   (in_rd),
      .i_rs1  (in_rs1),
      .i_rs2  (in_rs2),
      .i_imm  (in_imm),
      .o_word (w_word)
   );

   assign in_ready  = !clr && (!r_valid || out_ready);
   assign w_acc     = in_valid && in_ready;
   assign out_valid = r_valid;
   assign out_instr = r_instr;
   assign out_addr  = r_addr;
   assign out_err   = r_err;
   assign err_cnt   = r_err_cnt;

   // output buffer: load on accept, drain on consume, flush on clr
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_instr   <= NOP;
         r_addr    <= '0;
         r_next    <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else if (clr) begin
         r_valid   <= 1'b0;
         r_addr    <= '0;
         r_next    <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else if (w_acc) begin
         r_valid <= 1'b1;
         r_instr <= w_word.instr;
         r_addr  <= r_next;
         r_err   <= w_word.err;
         r_next  <= r_next + ADDR_W'(1);
         if (w_word.err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sr_instr_encoder.sv
// tb_sr_instr_encoder: randomized and directed stimulus checked every cycle against a behavioural model
module tb_sr_instr_encoder;

   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [4:0]    in_op = '0;
   logic [4:0]    in_rd = '0;
   logic [4:0]    in_rs1 = '0;
   logic [4:0]    in_rs2 = '0;
   logic [31:0]   in_imm = '0;
   logic          in_ready;
   logic          out_valid;
   logic          out_err;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_addr;
   logic [7:0]    err_cnt;

   int checks = 0;
   int errors = 0;

   sr_instr_encoder #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .out_err   (out_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] fld(input int v, input int lsb, input int width);
      logic [31:0] t;
      t = 32'(v & ((1 << width) - 1));
      return t << lsb;
   endfunction

   // reference encoder: returns {err, instr} straight from the RV32I field layout
   function automatic logic [32:0] ref_enc(input int op, input int rd, input int rs1, input int rs2,
                                           input logic [31:0] imm);
      int          r_f3 [8] = '{0, 0, 6, 7, 4, 1, 5, 3};
      int          i_f3 [4] = '{0, 7, 6, 4};
      int          b_f3 [4] = '{0, 1, 4, 5};
      int          s;
      logic [31:0] w;
      bit          bad;
      s   = $signed(imm);
      bad = 0;
      w   = 32'h13;
      if (op <= 7) begin
         w = fld(op == 1 ? 32 : 0, 25, 7) | fld(rs2, 20, 5) | fld(rs1, 15, 5) | fld(r_f3[op], 12, 3)
           | fld(rd, 7, 5) | 32'd51;
      end else if (op <= 11) begin
         w = fld(s, 20, 12) | fld(rs1, 15, 5) | fld(i_f3[op-8], 12, 3) | fld(rd, 7, 5) | 32'd19;
`ifdef SR_ENC_RANGECHK_EN
         bad = (s < -2048) || (s > 2047);
`endif
      end else if (op <= 13) begin
         w = fld(s, 20, 5) | fld(rs1, 15, 5) | fld(op == 12 ? 1 : 5, 12, 3) | fld(rd, 7, 5) | 32'd19;
`ifdef SR_ENC_RANGECHK_EN
         bad = (s < 0) || (s > 31);
`endif
      end else if (op == 14) begin
         w = (imm & 32'hFFFF_F000) | fld(rd, 7, 5) | 32'd55;
`ifdef SR_ENC_RANGECHK_EN
         bad = (imm & 32'hFFF) != 0;
`endif
      end else if (op <= 18) begin
         w = fld(s >>> 12, 31, 1) | fld(s >>> 5, 25, 6) | fld(rs2, 20, 5) | fld(rs1, 15, 5)
           | fld(b_f3[op-15], 12, 3) | fld(s >>> 1, 8, 4) | fld(s >>> 11, 7, 1) | 32'd99;
`ifdef SR_ENC_RANGECHK_EN
         bad = (s < -4096) || (s > 4094) || (s % 2 != 0);
`endif
      end else begin
         bad = 1;
      end
      return {bad, bad ? 32'h13 : w};
   endfunction

   // behavioural model of the output stage
   logic        m_valid = 1'b0;
   logic [31:0] m_instr = 32'h13;
   int          m_addr = 0;
   int          m_next = 0;
   logic        m_err = 1'b0;
   int          m_errcnt = 0;
   logic [32:0] m_enc;

   assign m_enc = ref_enc(in_op, in_rd, in_rs1, in_rs2, in_imm);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || clr) begin
         m_valid  <= 1'b0;
         m_next   <= 0;
         m_errcnt <= 0;
      end else if (in_valid && (!m_valid || out_ready)) begin
         m_valid  <= 1'b1;
         m_instr  <= m_enc[31:0];
         m_err    <= m_enc[32];
         m_addr   <= m_next;
         m_next   <= (m_next + 1) % (1 << AW);
         m_errcnt <= (m_enc[32] && m_errcnt < 255) ? m_errcnt + 1 : m_errcnt;
      end else if (out_ready) begin
         m_valid <= 1'b0;
      end
   end

   int          got_addr [$];
   logic [31:0] got_instr [$];

   // compare process: every negedge against the model, and log consumed words
   initial forever begin
      @(negedge clk);
      chk("in_ready", 33'(in_ready), 33'(!clr && (!m_valid || out_ready)));
      chk("out_valid", 33'(out_valid), 33'(m_valid));
      chk("err_cnt", 33'(err_cnt), 33'(m_errcnt));
      if (m_valid) begin
         chk("out_instr", 33'(out_instr), 33'(m_instr));
         chk("out_addr", 33'(out_addr), 33'(m_addr));
         chk("out_err", 33'(out_err), 33'(m_err));
      end
      if (out_valid && out_ready) begin
         got_addr.push_back(int'(out_addr));
         got_instr.push_back(out_instr);
      end
   end

   task automatic drive(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
      in_op  = 5'(op);
      in_rd  = 5'(rd);
      in_rs1 = 5'(rs1);
      in_rs2 = 5'(rs2);
      in_imm = imm;
   endtask

   // one request with out_ready high; checks the registered word one cycle later
   task automatic send(input string name, input int op, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input logic [31:0] exp_instr, input logic exp_err);
      @(posedge clk); #1;
      drive(op, rd, rs1, rs2, imm);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({name, ".valid"}, 33'(out_valid), 33'd1);
      chk({name, ".instr"}, 33'(out_instr), 33'(exp_instr));
      chk({name, ".err"}, 33'(out_err), 33'(exp_err));
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1;
      in_valid = 1'b0;
      clr      = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   initial begin
      logic [31:0] w0;
      logic [31:0] exp_i [5];
      int          exp_a [5] = '{0, 1, 2, 3, 0};
      int          bnd [12] = '{-4097, -4096, -2049, -2048, -1, 0, 1, 31, 32, 2047, 2048, 4094};

      chk("model.add", ref_enc(0, 1, 2, 3, 0), 33'h0_003100B3);
      chk("model.beq", ref_enc(15, 0, 1, 2, 8), 33'h0_00208463);
      chk("model.bne_neg", ref_enc(16, 0, 3, 4, -32'sd4), 33'h0_FE419EE3);
      chk("model.lui", ref_enc(14, 1, 0, 0, 32'h12345000), 33'h0_123450B7);

      @(negedge clk);
      chk("rst.out_valid", 33'(out_valid), 33'd0);
      chk("rst.out_instr", 33'(out_instr), 33'h13);
      chk("rst.out_addr", 33'(out_addr), 33'd0);
      chk("rst.out_err", 33'(out_err), 33'd0);
      chk("rst.err_cnt", 33'(err_cnt), 33'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      send("add", 0, 1, 2, 3, 0, 32'h003100B3, 1'b0);
      chk("add.addr", 33'(out_addr), 33'd0);
      send("sub", 1, 1, 2, 3, 0, 32'h403100B3, 1'b0);
      chk("sub.addr", 33'(out_addr), 33'd1);
      send("addi", 8, 5, 0, 0, 32'hFFFF_FFFF, 32'hFFF00293, 1'b0);
      send("srli", 13, 1, 2, 0, 4, 32'h00415093, 1'b0);
      send("lui", 14, 1, 0, 0, 32'h12345000, 32'h123450B7, 1'b0);
      send("beq", 15, 0, 1, 2, 8, 32'h00208463, 1'b0);

      pulse_clr();
      send("illegal", 31, 1, 2, 3, 0, 32'h13, 1'b1);
      chk("illegal.err_cnt", 33'(err_cnt), 33'd1);
`ifdef SR_ENC_RANGECHK_EN
      send("addi2048", 8, 0, 0, 0, 2048, 32'h13, 1'b1);
      chk("addi2048.err_cnt", 33'(err_cnt), 33'd2);
`else
      send("addi2048", 8, 0, 0, 0, 2048, 32'h80000013, 1'b0);
      chk("addi2048.err_cnt", 33'(err_cnt), 33'd1);
`endif

      // stall: accept word 0, hold out_ready low for 5 cycles, then drain 5 words
      pulse_clr();
      for (int k = 0; k < 5; k++) exp_i[k] = ref_enc(8, k + 1, k, 0, k * 3)[31:0];
      got_addr.delete();
      got_instr.delete();
      @(posedge clk); #1;
      drive(8, 1, 0, 0, 0);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      drive(8, 2, 1, 0, 3);
      w0 = exp_i[0];
      repeat (5) begin
         @(negedge clk);
         chk("stall.in_ready", 33'(in_ready), 33'd0);
         chk("stall.out_instr", 33'(out_instr), 33'(w0));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 2; k < 5; k++) begin
         @(posedge clk); #1;
         drive(8, k + 1, k, 0, k * 3);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("stall.count", 33'(got_addr.size()), 33'd5);
      for (int k = 0; k < 5 && k < got_addr.size(); k++) begin
         chk("stall.addr", 33'(got_addr[k]), 33'(exp_a[k]));
         chk("stall.instr", 33'(got_instr[k]), 33'(exp_i[k]));
      end

      // clr in the same cycle as a pending word and an offered request
      send("pre_clr_err", 31, 0, 0, 0, 0, 32'h13, 1'b1);
      @(posedge clk); #1;
      drive(0, 4, 5, 6, 0);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      drive(1, 7, 8, 9, 0);
      clr       = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("clr.in_ready", 33'(in_ready), 33'd0);
      chk("clr.pending", 33'(out_valid), 33'd1);
      @(posedge clk); #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("clr.out_valid", 33'(out_valid), 33'd0);
      chk("clr.err_cnt", 33'(err_cnt), 33'd0);
      send("post_clr", 4, 3, 2, 1, 0, 32'h001141B3, 1'b0);
      chk("post_clr.addr", 33'(out_addr), 33'd0);

      // randomized traffic with occasional clr and one mid-stream reset
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (c == 1500) rst_n = 1'b0;
         if (c == 1503) rst_n = 1'b1;
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         clr       = ($urandom % 100) == 0;
         in_op     = ($urandom % 8 == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
         in_rd     = 5'($urandom);
         in_rs1    = 5'($urandom);
         in_rs2    = 5'($urandom);
         case ($urandom % 4)
            0:       in_imm = $urandom;
            1:       in_imm = 32'($signed(bnd[$urandom % 12]));
            2:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            default: in_imm = {$urandom, 12'h000} | ($urandom % 2 == 0 ? 32'h0 : 32'h1);
         endcase
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      clr      = 1'b0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sr_instr_encoder.md
Name: sr_instr_encoder

Overview:
- Streaming RV32I instruction encoder; the inverse of the core's control decoder.
- Accepts a mnemonic code plus rd/rs1/rs2/imm fields and emits packed 32-bit instruction words with a running word address.
- Registered output with a valid/ready handshake; used by the on-chip program loader and self-test sequencer to fill instruction memory.
- Covers exactly the instruction set the core executes: ADD, SUB, OR, AND, XOR, SLL, SRL, SLTU, ADDI, ANDI, ORI, XORI, SLLI, SRLI, LUI, BEQ, BNE, BLT, BGE.

Parameters:
- ADDR_W, 8, width of the output word-address counter; wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: empties the output stage, zeroes the address and error count
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_op  in  5  mnemonic code (ENC_OP_*)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  signed immediate, or byte offset for branches; upper 20 bits for LUI
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word index of out_instr
- out_err  out  1  this word was substituted because the request was illegal
- err_cnt  out  8  saturating count of errored words emitted

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_instr=32'h00000013 (NOP), out_addr=0, out_err=0, err_cnt=0.
- in_ready = !out_valid | out_ready, giving full throughput and a one-entry output buffer.
- Accept when in_valid & in_ready. The word is registered and appears on the next cycle, so latency is 1 clock.
- out_valid rises on accept and stays high until out_valid & out_ready.
- While stalled, out_instr, out_addr and out_err are held stable.
- Back-to-back: a word can be consumed and a new request accepted in the same cycle.
- Address: an internal counter holds the address of the next accepted word.
  - Each accept loads that value into out_addr, then the counter increments.
  - The counter wraps from 2^ADDR_W-1 to 0 silently.
- R-type: funct7 / rs2 / rs1 / funct3 / rd / opcode 0110011. SUB uses funct7 0100000; every other R-type uses 0000000.
- I-type ALU (ADDI/ANDI/ORI/XORI): imm[11:0] / rs1 / funct3 / rd / 0010011.
- SLLI/SRLI: funct7 0000000 / shamt = in_imm[4:0] / rs1 / funct3 / rd / 0010011.
- LUI: in_imm[31:12] / rd / 0110111. Bits [11:0] of in_imm are ignored.
- Branches: imm[12] / imm[10:5] / rs2 / rs1 / funct3 / imm[4:1] / imm[11] / 1100011, with funct3 = 000 BEQ, 001 BNE, 100 BLT, 101 BGE. in_imm[0] is dropped.
- Fields that an instruction format does not use are ignored.
- Illegal in_op (code outside the table): emit NOP 32'h00000013 with out_err=1. The address still advances.
- err_cnt increments on each emitted word with out_err=1 and saturates at 255.
- clr has priority over everything in the same cycle:
  - out_valid=0 and any pending word is discarded.
  - The address counter and err_cnt are set to 0.
  - in_ready is forced to 0 that cycle, so no request is accepted.
- Reset mid-stream discards the pending word; there is no partial state.

Optional Feature:
- Macro SR_ENC_RANGECHK_EN.
- Defined: the immediate is range-checked; a failing request emits NOP with out_err=1. A request fails when:
  - I-type ALU: in_imm is outside [-2048, 2047].
  - Shifts: in_imm is outside [0, 31].
  - Branches: in_imm is outside [-4096, 4094] or odd.
  - LUI: in_imm[11:0] != 0.
- Not defined: immediates are truncated to the field width with no checking; out_err reflects only illegal in_op.

Decomposition:
- Shared header sr_cpu.vh:
  - Add ENC_OP_* 5-bit mnemonic codes.
  - Add the NOP constant.
  - Reuse the existing RVOP_*, RVF3_* and RVF7_* encodings, so encoder and decoder share one source of truth.
- Sub-module sr_enc_pack: purely combinational op+fields -> {instr, err}, including the range check.
- The top level holds the handshake register, address counter and err_cnt.

Test Plan:
- ADD rd=1 rs1=2 rs2=3 -> out_instr 32'h003100B3, out_addr 0, one cycle after accept.
- SUB 1,2,3 -> 32'h403100B3; ADDI rd=5 rs1=0 imm=-1 -> 32'hFFF00293; SRLI 1,2,4 -> 32'h00415093.
- LUI rd=1 imm=32'h12345000 -> 32'h123450B7; BEQ rs1=1 rs2=2 imm=8 -> 32'h00208463.
- Hold out_ready=0 for 5 cycles while in_valid=1:
  - Expect in_ready=0 and out_instr stable for those cycles.
  - On release, expect no loss or duplication across 4 words at addresses 0..3.
  - With ADDR_W=2, the 5th word is at out_addr 0.
- Illegal in_op=31 -> NOP with out_err=1 and err_cnt=1.
  - With SR_ENC_RANGECHK_EN, ADDI imm=2048 -> NOP with out_err=1.
  - Without it, ADDI imm=2048 -> 32'h80000013.
- clr asserted in the same cycle as an accept and a pending out_valid:
  - Next cycle expect out_valid=0, err_cnt=0.
  - The next accepted word gets out_addr 0.
